// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: h/v counters, blanking, syncs and strobes
// from runtime-writable timing registers committed at frame wrap.
module video_timing_gen #(
    parameter int unsigned HW          = 9,
    parameter int unsigned VW          = 9,
    parameter int unsigned HTOTAL_D    = 383,
    parameter int unsigned HBL_START_D = 263,
    parameter int unsigned HBL_END_D   = 7,
    parameter int unsigned HS_START_D  = 300,
    parameter int unsigned HS_END_D    = 332,
    parameter int unsigned VTOTAL_D    = 263,
    parameter int unsigned VBL_START_D = 240,
    parameter int unsigned VBL_END_D   = 16,
    parameter int unsigned VS_START_D  = 251,
    parameter int unsigned VS_END_D    = 259
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk_pix_en,
    input  logic [3:0]    hs_offset,
    input  logic [3:0]    vs_offset,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [15:0]   cfg_data,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic          hsync,
    output logic          vsync,
    output logic          hbl,
    output logic          vbl,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          field
);

    // Common width for window compares; vertical uses a half-line index (VW+1 bits).
    localparam int unsigned XW = (HW > VW + 1) ? HW : VW + 1;

    typedef struct packed {
        logic [HW-1:0] htotal;
        logic [HW-1:0] hbl_s;
        logic [HW-1:0] hbl_e;
        logic [HW-1:0] hs_s;
        logic [HW-1:0] hs_e;
        logic [VW-1:0] vtotal;
        logic [VW-1:0] vbl_s;
        logic [VW-1:0] vbl_e;
        logic [VW-1:0] vs_s;
        logic [VW-1:0] vs_e;
        logic [2:0]    ctrl;
    } regs_t;

    localparam regs_t REGS_D = '{
        htotal: HW'(HTOTAL_D),   hbl_s: HW'(HBL_START_D), hbl_e: HW'(HBL_END_D),
        hs_s:   HW'(HS_START_D), hs_e:  HW'(HS_END_D),
        vtotal: VW'(VTOTAL_D),   vbl_s: VW'(VBL_START_D), vbl_e: VW'(VBL_END_D),
        vs_s:   VW'(VS_START_D), vs_e:  VW'(VS_END_D),
        ctrl:   3'd0
    };

    function automatic regs_t write_reg(input regs_t r, input logic [3:0] a, input logic [15:0] d);
        regs_t w;
        w = r;
        case (a)
            4'd0:    w.htotal = d[HW-1:0];
            4'd1:    w.hbl_s  = d[HW-1:0];
            4'd2:    w.hbl_e  = d[HW-1:0];
            4'd3:    w.hs_s   = d[HW-1:0];
            4'd4:    w.hs_e   = d[HW-1:0];
            4'd5:    w.vtotal = d[VW-1:0];
            4'd6:    w.vbl_s  = d[VW-1:0];
            4'd7:    w.vbl_e  = d[VW-1:0];
            4'd8:    w.vs_s   = d[VW-1:0];
            4'd9:    w.vs_e   = d[VW-1:0];
            4'd10:   w.ctrl   = d[2:0];
            default: w = r;
        endcase
        return w;
    endfunction

    // s<e: [s,e); s>e: wraps through 0; s==e: never.
    function automatic logic in_win(input logic [XW-1:0] x, input logic [XW-1:0] s,
                                    input logic [XW-1:0] e);
        if (s < e) return (x >= s) && (x < e);
        if (s > e) return (x >= s) || (x < e);
        return 1'b0;
    endfunction

    function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] base, input logic [3:0] off,
                                              input logic [HW-1:0] lim);
        logic signed [HW:0] sum;
        sum = $signed({1'b0, base}) + (HW+1)'($signed(off));
        if (sum < 0) return '0;
        if ($unsigned(sum) > {1'b0, lim}) return lim;
        return sum[HW-1:0];
    endfunction

    function automatic logic [VW-1:0] clamp_v(input logic [VW-1:0] base, input logic [3:0] off,
                                              input logic [VW-1:0] lim);
        logic signed [VW:0] sum;
        sum = $signed({1'b0, base}) + (VW+1)'($signed(off));
        if (sum < 0) return '0;
        if ($unsigned(sum) > {1'b0, lim}) return lim;
        return sum[VW-1:0];
    endfunction

    regs_t         shadow, active, shadow_wr, act_n;
    logic          hwrap, vwrap, commit, field_n, odd;
    logic [VW:0]   vlast, hpos;
    logic [HW-1:0] hc_n, hs_s, hs_e, hmid;
    logic [VW-1:0] vc_n, vs_s, vs_e;
    logic          hbl_n, vbl_n, hs_n, vs_n;
    logic          unused_cfg;

    assign unused_cfg = ^cfg_data;

    // Next counters, commit and output decode of the new position.
    always_comb begin
        shadow_wr = cfg_we ? write_reg(shadow, cfg_addr, cfg_data) : shadow;
        hwrap     = (hc >= active.htotal);
        vlast     = {1'b0, active.vtotal} + (VW+1)'(active.ctrl[0] & field);
        vwrap     = ({1'b0, vc} >= vlast);
        commit    = clk_pix_en & hwrap & vwrap;
        act_n     = commit ? shadow_wr : active;

        hc_n    = hwrap ? '0 : hc + HW'(1);
        vc_n    = vc;
        if (hwrap) vc_n = vwrap ? '0 : vc + VW'(1);
        field_n = act_n.ctrl[0] & (field ^ (hwrap & vwrap));

        hs_s = clamp_h(act_n.hs_s, hs_offset, act_n.htotal);
        hs_e = clamp_h(act_n.hs_e, hs_offset, act_n.htotal);
        vs_s = clamp_v(act_n.vs_s, vs_offset, act_n.vtotal);
        vs_e = clamp_v(act_n.vs_e, vs_offset, act_n.vtotal);

        // Odd field: vsync edges move to mid-line, i.e. one half-line later.
        hmid = HW'(({1'b0, act_n.htotal} + (HW+1)'(1)) >> 1);
        odd  = act_n.ctrl[0] & field_n;
        hpos = {vc_n, odd & (hc_n >= hmid)};

        hbl_n = in_win(XW'(hc_n), XW'(act_n.hbl_s), XW'(act_n.hbl_e));
        vbl_n = in_win(XW'(vc_n), XW'(act_n.vbl_s), XW'(act_n.vbl_e));
        hs_n  = in_win(XW'(hc_n), XW'(hs_s), XW'(hs_e)) ^ act_n.ctrl[1];
        vs_n  = in_win(XW'(hpos), XW'({vs_s, odd}), XW'({vs_e, odd})) ^ act_n.ctrl[2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow      <= REGS_D;
            active      <= REGS_D;
            hc          <= '0;
            vc          <= '0;
            field       <= 1'b0;
            hbl         <= 1'b0;
            vbl         <= 1'b0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            shadow      <= shadow_wr;
            active      <= act_n;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (clk_pix_en) begin
                hc          <= hc_n;
                vc          <= vc_n;
                field       <= field_n;
                hbl         <= hbl_n;
                vbl         <= vbl_n;
                de          <= ~hbl_n & ~vbl_n;
                hsync       <= hs_n;
                vsync       <= vs_n;
                line_start  <= (hc_n == '0);
                frame_start <= (hc_n == '0) && (vc_n == '0);
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: randomized enables, offsets and config writes checked
// every cycle against an integer raster model.
module tb_video_timing_gen;

    localparam int HT_D = 63, HBS_D = 50, HBE_D = 4, HSS_D = 54, HSE_D = 58;
    localparam int VT_D = 23, VBS_D = 20, VBE_D = 3, VSS_D = 21, VSE_D = 22;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_pix_en;
    logic [3:0]  hs_offset, vs_offset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [8:0]  hc, vc;
    logic        hsync, vsync, hbl, vbl, de, line_start, frame_start, field;

    video_timing_gen #(
        .HW(9), .VW(9),
        .HTOTAL_D(HT_D), .HBL_START_D(HBS_D), .HBL_END_D(HBE_D),
        .HS_START_D(HSS_D), .HS_END_D(HSE_D),
        .VTOTAL_D(VT_D), .VBL_START_D(VBS_D), .VBL_END_D(VBE_D),
        .VS_START_D(VSS_D), .VS_END_D(VSE_D)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_pix_en(clk_pix_en),
        .hs_offset(hs_offset), .vs_offset(vs_offset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync), .hbl(hbl), .vbl(vbl),
        .de(de), .line_start(line_start), .frame_start(frame_start), .field(field)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int act[11];
    int shw[11];
    int mhc, mvc, mfield;
    bit e_hbl, e_vbl, e_de, e_hs, e_vs, e_ls, e_fs;

    function automatic bit win(input int x, input int s, input int e);
        if (s < e) return (x >= s) && (x < e);
        if (s > e) return (x >= s) || (x < e);
        return 1'b0;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        act = '{HT_D, HBS_D, HBE_D, HSS_D, HSE_D, VT_D, VBS_D, VBE_D, VSS_D, VSE_D, 0};
        shw = act;
        mhc = 0; mvc = 0; mfield = 0;
        e_hbl = 0; e_vbl = 0; e_de = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_fs = 0;
    endtask

    task automatic model_edge(input bit en, input bit we, input int a, input int d,
                              input int ho, input int vo);
        int  vlast, s, e, ht, vt;
        bit  hw, vw;
        if (we && a <= 10) shw[a] = (a == 10) ? (d & 7) : (d & 511);
        e_ls = 0; e_fs = 0;
        if (en) begin
            hw    = (mhc >= act[0]);
            vlast = act[5] + (((act[10] & 1) != 0 && mfield != 0) ? 1 : 0);
            vw    = (mvc >= vlast);
            if (hw) begin
                mhc = 0;
                mvc = vw ? 0 : mvc + 1;
            end else begin
                mhc = mhc + 1;
            end
            if (hw && vw) act = shw;
            if ((act[10] & 1) != 0) begin
                if (hw && vw) mfield = 1 - mfield;
            end else begin
                mfield = 0;
            end
            ht = act[0]; vt = act[5];
            e_hbl = win(mhc, act[1], act[2]);
            e_vbl = win(mvc, act[6], act[7]);
            e_de  = !e_hbl && !e_vbl;
            s = clampi(act[3] + ho, 0, ht);
            e = clampi(act[4] + ho, 0, ht);
            e_hs = win(mhc, s, e) ^ ((act[10] >> 1) & 1);
            s = clampi(act[8] + vo, 0, vt);
            e = clampi(act[9] + vo, 0, vt);
            if ((act[10] & 1) != 0 && mfield != 0)
                e_vs = (mhc >= (ht + 1) / 2) ? win(mvc, s, e) : win(mvc - 1, s, e);
            else
                e_vs = win(mvc, s, e);
            e_vs = e_vs ^ ((act[10] >> 2) & 1);
            e_ls = (mhc == 0);
            e_fs = (mhc == 0) && (mvc == 0);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("hc", 32'(hc), 32'(mhc));
        chk("vc", 32'(vc), 32'(mvc));
        chk("field", 32'(field), 32'(mfield));
        chk("hbl", 32'(hbl), 32'(e_hbl));
        chk("vbl", 32'(vbl), 32'(e_vbl));
        chk("de", 32'(de), 32'(e_de));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic tick(input bit en, input bit we, input logic [3:0] a, input logic [15:0] d);
        logic signed [3:0] hos, vos;
        clk_pix_en = en; cfg_we = we; cfg_addr = a; cfg_data = d;
        hos = hs_offset; vos = vs_offset;
        @(posedge clk);
        model_edge(en, we, int'(a), int'(d), int'(hos), int'(vos));
        #1 check_all();
    endtask

    function automatic logic [15:0] rnd_data(input logic [3:0] a);
        int v;
        case (a)
            4'd0:                   v = $urandom_range(24, 60);
            4'd1, 4'd2, 4'd3, 4'd4: v = $urandom_range(0, 62);
            4'd5:                   v = $urandom_range(10, 28);
            4'd6, 4'd7, 4'd8, 4'd9: v = $urandom_range(0, 30);
            4'd10:                  v = $urandom_range(0, 7);
            default:                v = $urandom_range(0, 65535);
        endcase
        if (a <= 4'd10) v = v | (int'($urandom_range(0, 127)) << 9);
        return 16'(v);
    endfunction

    task automatic run_rand(input int n, input int we_pct);
        logic [3:0] a;
        for (int i = 0; i < n; i++) begin
            a = 4'($urandom_range(0, 15));
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 99) < we_pct, a, rnd_data(a));
        end
    endtask

    int guard;

    initial begin
        reset_n = 1'b0; clk_pix_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        hs_offset = '0; vs_offset = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 check_all();
        reset_n = 1'b1;

        // Defaults, continuous enable: first edge gives hc=1, then over a full frame
        tick(1, 0, 4'd0, 16'd0);
        chk("first_hc", 32'(hc), 32'd1);
        for (int i = 0; i < 1600; i++) tick(1, 0, 4'd0, 16'd0);

        // Fixed offsets hs -4 / vs +3 with random pixel enable
        hs_offset = 4'hC; vs_offset = 4'd3;
        run_rand(1600, 0);

        // Offsets changing on the fly, including clamp cases
        for (int i = 0; i < 16; i++) begin
            hs_offset = 4'($urandom_range(0, 15));
            vs_offset = 4'($urandom_range(0, 15));
            run_rand(50, 0);
        end
        hs_offset = '0; vs_offset = '0;

        // HTOTAL rewrite mid-frame only lands at the next frame wrap
        guard = 0;
        while (mvc != 10 && guard < 4000) begin tick(1, 0, 4'd0, 16'd0); guard++; end
        chk("wait_vc10", 32'(vc), 32'd10);
        tick(1, 1, 4'd0, 16'd40);
        run_rand(2400, 0);

        // Wrapping hsync window, then an empty one
        tick(1, 1, 4'd3, 16'd30);
        tick(1, 1, 4'd4, 16'd5);
        run_rand(2200, 0);
        tick(1, 1, 4'd4, 16'd30);
        run_rand(2200, 0);

        // Interlace with a visible vsync window
        tick(1, 1, 4'd8, 16'd5);
        tick(1, 1, 4'd9, 16'd8);
        tick(1, 1, 4'd10, 16'd1);
        run_rand(6000, 0);

        // Inverted sync polarities
        tick(1, 1, 4'd10, 16'd6);
        run_rand(2400, 0);

        // A write on the commit cycle itself is committed
        guard = 0;
        while (!(mhc >= act[0] && mvc >= act[5] + (((act[10] & 1) != 0 && mfield != 0) ? 1 : 0))
               && guard < 4000) begin
            tick(1, 0, 4'd0, 16'd0); guard++;
        end
        tick(1, 1, 4'd0, 16'd33);
        chk("commit_frame_start", 32'(frame_start), 32'd1);
        run_rand(1500, 0);

        // Random configuration traffic
        run_rand(15000, 5);

        // Asynchronous reset mid-frame with the pixel enable high
        guard = 0;
        while (!(mvc == 12 && mhc == 15) && guard < 4000) begin tick(1, 0, 4'd0, 16'd0); guard++; end
        chk("wait_mid", 32'(vc), 32'd12);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        clk_pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        tick(1, 0, 4'd0, 16'd0);
        chk("post_reset_hc", 32'(hc), 32'd1);
        for (int i = 0; i < 1600; i++) tick(1, 0, 4'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
